cordic_rr_scheduler: RTL and testbench

//  Shares one combinational CORDIC_ALGO core between N_REQ angle requesters. Arbitrates

---
 rtl/cordic_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/cordic_rr_scheduler.sv | 144 ++++++++++++++
 tb/tb_cordic_rr_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, fixed-point type and FSM state encoding for the shared CORDIC
// scheduling blocks.
package cordic_pkg;

  localparam int FRAC_BITS  = 28;
  localparam int K_GAIN     = 163007430;
  localparam int PI_Q28     = 843314857;
  localparam int TWO_PI_Q28 = 1686629713;

  typedef logic signed [31:0] q4_28_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping past N-1 back to 0.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  always_comb begin
    int unsigned j;
    logic [IW-1:0] jn;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jn    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      jn = IW'(j);
      if (!any && req[jn]) begin
        any       = 1'b1;
        grant[jn] = 1'b1;
        idx       = jn;
      end
    end
  end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Round-robin scheduler sharing one combinational CORDIC core among N_REQ requesters:
// grants, range-reduces the angle, waits for the core to settle, returns cos/sin + ID.
module cordic_rr_scheduler
  import cordic_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CORDIC_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_angle,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]         rsp_cos,
  output logic [WIDTH-1:0]         rsp_sin,
  output logic [WIDTH-1:0]         core_x,
  output logic [WIDTH-1:0]         core_y,
  output logic [WIDTH-1:0]         core_angle,
  input  logic [WIDTH-1:0]         core_cos,
  input  logic [WIDTH-1:0]         core_sin,
  output logic                     busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(CORDIC_LAT + 1);
  localparam logic signed [WIDTH-1:0] TWO_PI_W = WIDTH'(TWO_PI_Q28);

  sched_state_e             state_q, state_d;
  logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]            id_q, id_d;
  logic signed [WIDTH-1:0]  angle_q, angle_d;
  logic [WIDTH-1:0]         core_angle_q, core_angle_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]         rsp_cos_q, rsp_cos_d;
  logic [WIDTH-1:0]         rsp_sin_q, rsp_sin_d;

  logic [N_REQ-1:0]         arb_grant;
  logic [IW-1:0]            arb_idx;
  logic                     arb_any;
  logic signed [WIDTH-1:0]  angle_red;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Single correction step; the modular WIDTH-bit add is exact because the reduced
  // angle always lies in [0, 2*pi), which fits signed Q4.28.
  always_comb begin
    angle_red = angle_q;
    if (angle_q[WIDTH-1])
      angle_red = angle_q + TWO_PI_W;
    else if (angle_q >= TWO_PI_W)
      angle_red = angle_q - TWO_PI_W;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    angle_d      = angle_q;
    core_angle_d = core_angle_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_cos_d    = rsp_cos_q;
    rsp_sin_d    = rsp_sin_q;
    req_ready    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          angle_d   = req_angle[32'(arb_idx)*WIDTH +: WIDTH];
          id_d      = arb_idx;
          rr_ptr_d  = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_angle_d = angle_red;
        cnt_d        = CW'(CORDIC_LAT - 1);
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_cos_d   = core_cos;
          rsp_sin_d   = core_sin;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      angle_q      <= '0;
      core_angle_q <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_cos_q    <= '0;
      rsp_sin_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      angle_q      <= angle_d;
      core_angle_q <= core_angle_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_cos_q    <= rsp_cos_d;
      rsp_sin_q    <= rsp_sin_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_cos    = rsp_cos_q;
  assign rsp_sin    = rsp_sin_q;
  assign core_x     = WIDTH'(K_GAIN);
  assign core_y     = '0;
  assign core_angle = core_angle_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Scoreboard bench for cordic_rr_scheduler with a real-valued model of the shared
// CORDIC core that only answers for angles already reduced into [0, 2*pi).
module tb_cordic_rr_scheduler;
  import cordic_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int TOL = 4096;

  localparam int A30    = 140552357;
  localparam int A300   = 1405523573;
  localparam int A390   = 1827182070;
  localparam int AM330  = -1546077356;
  localparam int A90    = PI_Q28 / 2;
  localparam int COS30  = 232471924;
  localparam int HALF   = 134217728;
  localparam int ONE    = 1 << FRAC_BITS;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_angle = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [1:0]     rsp_id;
  q4_28_t         rsp_cos, rsp_sin, core_x, core_y, core_angle, core_cos, core_sin;
  logic           busy;

  cordic_rr_scheduler #(.N_REQ(N), .WIDTH(W), .CORDIC_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_angle  (req_angle),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_cos    (rsp_cos),
    .rsp_sin    (rsp_sin),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_angle (core_angle),
    .core_cos   (core_cos),
    .core_sin   (core_sin),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Core model: gain-compensated rotation of (core_x, core_y); unreduced angles give 0.
  real m_a, m_c, m_s;
  always_comb begin
    m_a      = 0.0;
    m_c      = 0.0;
    m_s      = 0.0;
    core_cos = '0;
    core_sin = '0;
    if (core_angle >= 0 && core_angle < TWO_PI_Q28) begin
      m_a = $itor(core_angle) / $itor(ONE);
      m_c = ($itor(core_x) * $cos(m_a) - $itor(core_y) * $sin(m_a)) / $itor(K_GAIN) * $itor(ONE);
      m_s = ($itor(core_y) * $cos(m_a) + $itor(core_x) * $sin(m_a)) / $itor(K_GAIN) * $itor(ONE);
      core_cos = $rtoi(m_c + ((m_c >= 0.0) ? 0.5 : -0.5));
      core_sin = $rtoi(m_s + ((m_s >= 0.0) ? 0.5 : -0.5));
    end
  end

  typedef struct {
    int     id;
    longint cos_e;
    longint sin_e;
    longint ang_e;
    int     hs;
  } sb_t;

  sb_t    sb[$];
  int     exp_grant[$];
  int     checks = 0;
  int     errors = 0;
  q4_28_t t_eang[N];
  q4_28_t t_cos[N];
  q4_28_t t_sin[N];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    logic signed [63:0] d;
    d = obs - exp;
    checks++;
    assert (!$isunknown(obs) && d <= TOL && d >= -TOL) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (+/-%0d)", tag, obs, exp, TOL);
    end
  endtask

  task automatic set_req(input int i, input int ang, input int eang, input int ec, input int es);
    req_angle[i*W +: W] = ang;
    t_eang[i] = eang;
    t_cos[i]  = ec;
    t_sin[i]  = es;
  endtask

  // Called positioned at a falling edge; returns positioned at a falling edge.
  task automatic run_cycles(input int n_rsp, input int budget);
    int got = 0;
    int cyc = 0;
    int g;
    logic [N-1:0] clr;
    sb_t e;
    while (got < n_rsp && cyc < budget) begin
      clr = '0;
      #1;
      if (req_ready != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        chk("ready_onehot", $countones(req_ready), 1);
        chk("ready_subset", req_ready & ~req_valid, 0);
        if (exp_grant.size() > 0) chk("grant_order", g, exp_grant.pop_front());
        sb.push_back('{id: g, cos_e: t_cos[g], sin_e: t_sin[g], ang_e: t_eang[g], hs: cyc});
        clr = req_ready;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk_tol("rsp_cos", rsp_cos, e.cos_e);
          chk_tol("rsp_sin", rsp_sin, e.sin_e);
          chk("core_angle", core_angle, e.ang_e);
          chk("latency", cyc - e.hs, LAT + 2);
          got++;
        end
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~clr;
      @(negedge clk);
      cyc++;
    end
    chk("rsp_count", got, n_rsp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    q4_28_t c0, s0;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_cos", rsp_cos, 0);
    chk("rst_rsp_sin", rsp_sin, 0);
    chk("rst_core_x", core_x, K_GAIN);
    chk("rst_core_y", core_y, 0);
    chk("rst_core_angle", core_angle, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requests, including the wrap-around corrections.
    set_req(0, A30, A30, COS30, HALF);
    req_valid = 4'b0001;
    run_cycles(1, 20);
    set_req(1, A300, A300, HALF, -COS30);
    req_valid = 4'b0010;
    run_cycles(1, 20);
    set_req(0, A390, A30, COS30, HALF);
    req_valid = 4'b0001;
    run_cycles(1, 20);
    set_req(3, AM330, A30, COS30, HALF);
    req_valid = 4'b1000;
    run_cycles(1, 20);

    // All four at once with rr_ptr back at 0, then a sparse pair.
    set_req(0, A30, A30, COS30, HALF);
    set_req(1, A300, A300, HALF, -COS30);
    set_req(2, A90, A90, 0, ONE);
    set_req(3, 0, 0, ONE, 0);
    exp_grant = '{0, 1, 2, 3};
    req_valid = 4'b1111;
    run_cycles(4, 60);
    set_req(0, A390, A30, COS30, HALF);
    set_req(2, AM330, A30, COS30, HALF);
    exp_grant = '{0, 2};
    req_valid = 4'b0101;
    run_cycles(2, 40);

    // Backpressure on the response side.
    set_req(1, A300, A300, HALF, -COS30);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    n = 0;
    #1;
    while (!req_ready[1] && n < 20) begin @(negedge clk); #1; n++; end
    chk("bp_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    set_req(0, A30, A30, COS30, HALF);
    req_valid = 4'b0001;
    @(negedge clk);
    n = 0;
    #1;
    while (!rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_id", rsp_id, 1);
    chk_tol("bp_rsp_cos", rsp_cos, HALF);
    chk_tol("bp_rsp_sin", rsp_sin, -COS30);
    c0 = rsp_cos;
    s0 = rsp_sin;
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_cos", rsp_cos, c0);
      chk("bp_hold_sin", rsp_sin, s0);
      chk("bp_hold_id", rsp_id, 1);
      chk("bp_no_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_rsp_cleared", rsp_valid, 0);
    chk("bp_next_grant", req_ready, 4'b0001);
    run_cycles(1, 20);

    // Reset asserted while the core is settling.
    set_req(2, A90, A90, 0, ONE);
    req_valid = 4'b0100;
    n = 0;
    #1;
    while (!req_ready[2] && n < 20) begin @(negedge clk); #1; n++; end
    chk("rstw_grant", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_core_x", core_x, K_GAIN);
    chk("rstw_core_angle", core_angle, 0);
    chk("rstw_rsp_cos", rsp_cos, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("rstw_no_stale", rsp_valid, 0);
      chk("rstw_idle", busy, 0);
    end
    set_req(0, A30, A30, COS30, HALF);
    set_req(1, A300, A300, HALF, -COS30);
    set_req(2, A90, A90, 0, ONE);
    set_req(3, 0, 0, ONE, 0);
    exp_grant = '{0, 1, 2, 3};
    req_valid = 4'b1111;
    run_cycles(4, 60);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
